// File: rtl/cabac_bin_sched.sv
// -----------------------------------------------------------------------------
// cabac_bin_sched
// Shares one CABAC arithmetic decoder between NREQ syntax-element parsers.
// The module runs the per-slice engine init handshake and grants bin requests
// round-robin. It issues exactly one decode strobe per bin and returns the
// decoded bin to the granted requester.
// A context bin takes two cycles (CTX1, CTX2). A bypass, terminate or
// reserved bin takes one cycle. Every bin also spends one ARB cycle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   en                global enable (0 freezes state, forces strobes low)
//   i_slice_start     new slice pulse; outside IDLE it aborts the current bin
//   i_init_done       engine context tables initialised
//   o_init            one-cycle engine range/offset init pulse
//   i_req             per-requester bin request (held until its o_bin_vld)
//   i_req_type        2 bits/requester: 0 ctx, 1 bypass, 2 terminate, 3 rsvd
//   i_req_bank        3 bits/requester: ctx bank 0..4 (>4 maps to bank 0)
//   i_req_idx         IDXW bits/requester: context index
//   o_dec_en          one-hot per-bank context decode strobe
//   o_cm_idx          context index of the active context bin
//   o_byp_en          bypass strobe
//   o_term_en         terminate strobe
//   i_valid           engine context-bin valid
//   i_bin_ctx         per-bank context bin results
//   i_bin_byp         bypass bin result
//   i_bin_term        terminate bin result
//   o_bin             decoded bin
//   o_bin_vld         one-hot: bin for requester k valid this cycle
//   o_slice_end       pulse when a terminate bin of 1 is decoded
//   o_busy            scheduler not in IDLE
// Optional build macro CABAC_SCHED_STATS_EN adds the o_cnt_ctx, o_cnt_byp and
// o_cnt_term bin counters. The counters are 32 bits wide and wrap. They clear
// on rst and on entry to INIT.
// -----------------------------------------------------------------------------
module cabac_bin_sched #(
   parameter int NREQ = 4,
   parameter int IDXW = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              i_slice_start,
   input  logic              i_init_done,
   output logic              o_init,
   input  logic [NREQ-1:0]   i_req,
   input  logic [2*NREQ-1:0] i_req_type,
   input  logic [3*NREQ-1:0] i_req_bank,
   input  logic [IDXW*NREQ-1:0] i_req_idx,
   output logic [4:0]        o_dec_en,
   output logic [IDXW-1:0]   o_cm_idx,
   output logic              o_byp_en,
   output logic              o_term_en,
   input  logic              i_valid,
   input  logic [4:0]        i_bin_ctx,
   input  logic              i_bin_byp,
   input  logic              i_bin_term,
   output logic              o_bin,
   output logic [NREQ-1:0]   o_bin_vld,
   output logic              o_slice_end,
`ifdef CABAC_SCHED_STATS_EN
   output logic [31:0]       o_cnt_ctx,
   output logic [31:0]       o_cnt_byp,
   output logic [31:0]       o_cnt_term,
`endif
   output logic              o_busy
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_WAIT, S_ARB, S_CTX1, S_CTX2, S_BYP, S_TERM, S_RSV
   } state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   rr_q;
   logic [GW-1:0]   g_q;
   logic [2:0]      bank_q;
   logic [IDXW-1:0] cm_idx_q;

   // Per-requester request fields unpacked from the flat buses
   logic [1:0]      type_a [NREQ];
   logic [2:0]      bank_a [NREQ];
   logic [IDXW-1:0] idx_a  [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign type_a[gi] = i_req_type[2*gi +: 2];
         assign bank_a[gi] = i_req_bank[3*gi +: 3];
         assign idx_a[gi]  = i_req_idx[IDXW*gi +: IDXW];
      end
   endgenerate

   // Round-robin search. The first requester at or after rr_q wins.
   logic          found;
   logic [GW-1:0] win;
   logic [GW:0]   cand;
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_q} + (GW+1)'(k);
         if (cand >= (GW+1)'(NREQ)) cand = cand - (GW+1)'(NREQ);
         if (!found && i_req[cand[GW-1:0]]) begin
            found = 1'b1;
            win   = cand[GW-1:0];
         end
      end
   end

   logic [4:0]      bank_oh;
   logic [NREQ-1:0] g_oh;
   logic            grant;
   assign bank_oh = 5'b00001 << bank_q;
   assign g_oh    = {{(NREQ-1){1'b0}}, 1'b1} << g_q;

   always_comb begin
      state_d     = state_q;
      grant       = 1'b0;
      o_init      = 1'b0;
      o_dec_en    = '0;
      o_byp_en    = 1'b0;
      o_term_en   = 1'b0;
      o_bin       = 1'b0;
      o_bin_vld   = '0;
      o_slice_end = 1'b0;
      if (en) begin
         if (i_slice_start && state_q != S_IDLE) begin
            // Abort: drop whatever is in flight, no strobe and no bin delivered
            state_d = S_INIT;
         end else begin
            unique case (state_q)
               S_IDLE: if (i_slice_start) state_d = S_INIT;
               S_INIT: begin
                  o_init  = 1'b1;
                  state_d = S_WAIT;
               end
               S_WAIT: if (i_init_done) state_d = S_ARB;
               S_ARB: if (found) begin
                  grant = 1'b1;
                  unique case (type_a[win])
                     2'd0:    state_d = S_CTX1;
                     2'd1:    state_d = S_BYP;
                     2'd2:    state_d = S_TERM;
                     default: state_d = S_RSV;
                  endcase
               end
               S_CTX1: begin
                  o_dec_en = bank_oh;
                  state_d  = S_CTX2;
               end
               S_CTX2: begin
                  // Strobe stays up until the engine answers
                  o_dec_en = bank_oh;
                  if (i_valid) begin
                     o_bin     = i_bin_ctx[bank_q];
                     o_bin_vld = g_oh;
                     state_d   = S_ARB;
                  end
               end
               S_BYP: begin
                  o_byp_en  = 1'b1;
                  o_bin     = i_bin_byp;
                  o_bin_vld = g_oh;
                  state_d   = S_ARB;
               end
               S_TERM: begin
                  o_term_en = 1'b1;
                  o_bin     = i_bin_term;
                  o_bin_vld = g_oh;
                  if (i_bin_term) begin
                     o_slice_end = 1'b1;
                     state_d     = S_IDLE;
                  end else begin
                     state_d = S_ARB;
                  end
               end
               S_RSV: begin
                  o_bin_vld = g_oh;
                  state_d   = S_ARB;
               end
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_q     <= '0;
         g_q      <= '0;
         bank_q   <= '0;
         cm_idx_q <= '0;
      end else if (en) begin
         state_q <= state_d;
         if (grant) begin
            g_q    <= win;
            rr_q   <= (win == GW'(NREQ-1)) ? '0 : win + 1'b1;
            bank_q <= (bank_a[win] > 3'd4) ? 3'd0 : bank_a[win];
            if (type_a[win] == 2'd0) cm_idx_q <= idx_a[win];
         end
      end
   end

   assign o_cm_idx = cm_idx_q;
   assign o_busy   = (state_q != S_IDLE);

`ifdef CABAC_SCHED_STATS_EN
   logic [31:0] cnt_ctx_q, cnt_byp_q, cnt_term_q;
   always_ff @(posedge clk) begin
      if (rst || (en && state_d == S_INIT)) begin
         cnt_ctx_q  <= '0;
         cnt_byp_q  <= '0;
         cnt_term_q <= '0;
      end else if (|o_bin_vld) begin
         if (state_q == S_CTX2) cnt_ctx_q  <= cnt_ctx_q + 32'd1;
         if (state_q == S_BYP)  cnt_byp_q  <= cnt_byp_q + 32'd1;
         if (state_q == S_TERM) cnt_term_q <= cnt_term_q + 32'd1;
      end
   end
   assign o_cnt_ctx  = cnt_ctx_q;
   assign o_cnt_byp  = cnt_byp_q;
   assign o_cnt_term = cnt_term_q;
`endif

endmodule

// File: tb/tb_cabac_bin_sched.sv
// -----------------------------------------------------------------------------
// tb_cabac_bin_sched
// Directed, table-driven bench for cabac_bin_sched (NREQ=4, IDXW=6).
// Each record holds one cycle of inputs and the outputs expected during that
// cycle. Inputs are driven just after the rising edge. Outputs are compared
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_cabac_bin_sched;

   logic        clk = 1'b0;
   logic        rst, en, i_slice_start, i_init_done;
   logic        o_init;
   logic [3:0]  i_req;
   logic [7:0]  i_req_type;
   logic [11:0] i_req_bank;
   logic [23:0] i_req_idx;
   logic [4:0]  o_dec_en;
   logic [5:0]  o_cm_idx;
   logic        o_byp_en, o_term_en;
   logic        i_valid;
   logic [4:0]  i_bin_ctx;
   logic        i_bin_byp, i_bin_term;
   logic        o_bin;
   logic [3:0]  o_bin_vld;
   logic        o_slice_end, o_busy;
`ifdef CABAC_SCHED_STATS_EN
   logic [31:0] o_cnt_ctx, o_cnt_byp, o_cnt_term;
`endif

   always #5 clk = ~clk;

   cabac_bin_sched #(.NREQ(4), .IDXW(6)) dut (
      .clk(clk), .rst(rst), .en(en),
      .i_slice_start(i_slice_start), .i_init_done(i_init_done), .o_init(o_init),
      .i_req(i_req), .i_req_type(i_req_type), .i_req_bank(i_req_bank),
      .i_req_idx(i_req_idx), .o_dec_en(o_dec_en), .o_cm_idx(o_cm_idx),
      .o_byp_en(o_byp_en), .o_term_en(o_term_en), .i_valid(i_valid),
      .i_bin_ctx(i_bin_ctx), .i_bin_byp(i_bin_byp), .i_bin_term(i_bin_term),
      .o_bin(o_bin), .o_bin_vld(o_bin_vld), .o_slice_end(o_slice_end),
`ifdef CABAC_SCHED_STATS_EN
      .o_cnt_ctx(o_cnt_ctx), .o_cnt_byp(o_cnt_byp), .o_cnt_term(o_cnt_term),
`endif
      .o_busy(o_busy)
   );

   typedef struct {
      logic        rst, en, ss, idn;
      logic [3:0]  req;
      logic [7:0]  typ;
      logic [11:0] bank;
      logic [23:0] idx;
      logic        vl;
      logic [4:0]  bctx;
      logic        by, bt;
      // expected: {init, dec_en[4:0], cm_idx[5:0], byp, term, bin, vld[3:0], slice_end, busy}
      logic [20:0] exp;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   function automatic vec_t mk(
      input logic r, e, s, d, input logic [3:0] q, input logic [7:0] t,
      input logic [11:0] b, input logic [23:0] x, input logic vl,
      input logic [4:0] bc, input logic by, bt,
      input logic ei, input logic [4:0] ed, input logic [5:0] ec,
      input logic eby, ete, ebi, input logic [3:0] evl, input logic es, ebu);
      vec_t v;
      v.rst = r; v.en = e; v.ss = s; v.idn = d; v.req = q; v.typ = t;
      v.bank = b; v.idx = x; v.vl = vl; v.bctx = bc; v.by = by; v.bt = bt;
      v.exp = {ei, ed, ec, eby, ete, ebi, evl, es, ebu};
      return v;
   endfunction

   task automatic apply(input vec_t v, input string name);
      logic [20:0] act;
      @(posedge clk);
      #1;
      rst = v.rst; en = v.en; i_slice_start = v.ss; i_init_done = v.idn;
      i_req = v.req; i_req_type = v.typ; i_req_bank = v.bank; i_req_idx = v.idx;
      i_valid = v.vl; i_bin_ctx = v.bctx; i_bin_byp = v.by; i_bin_term = v.bt;
      @(negedge clk);
      act = {o_init, o_dec_en, o_cm_idx, o_byp_en, o_term_en, o_bin, o_bin_vld,
             o_slice_end, o_busy};
      n_vec++;
      if (act !== v.exp) begin
         n_bad++;
         $display("FAIL %s: got init=%b dec=%b idx=%0d byp=%b term=%b bin=%b vld=%b end=%b busy=%b, want init=%b dec=%b idx=%0d byp=%b term=%b bin=%b vld=%b end=%b busy=%b",
                  name, act[20], act[19:15], act[14:9], act[8], act[7], act[6], act[5:2], act[1], act[0],
                  v.exp[20], v.exp[19:15], v.exp[14:9], v.exp[8], v.exp[7], v.exp[6], v.exp[5:2], v.exp[1], v.exp[0]);
      end else begin
         $display("%s: ok dec=%b idx=%0d vld=%b bin=%b busy=%b", name, act[19:15], act[14:9], act[5:2], act[6], act[0]);
      end
   endtask

   vec_t tbl[$];

   initial begin
      // Reset, init handshake, ctx bin, round-robin, bypass burst, terminate
      //               rst en ss idn req     typ    bank    idx    vl bctx  by bt | init dec     cm byp term bin vld    end busy
      tbl.push_back(mk(1, 1, 0, 0, 4'b0000, 8'h00, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 4'b0000, 8'h00, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 8'h00, 12'h000, 24'd0, 0, 5'h00, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 4'b0000, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 8'h00, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 4'b0000, 0, 1));
      tbl.push_back(mk(0, 1, 0, 1, 4'b0000, 8'h00, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 4'b0000, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0001, 8'h00, 12'h003, 24'd17, 0, 5'h00, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 4'b0000, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0001, 8'h00, 12'h003, 24'd17, 0, 5'h00, 0, 0, 0, 5'b01000, 17, 0, 0, 0, 4'b0000, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0001, 8'h00, 12'h003, 24'd17, 1, 5'h08, 0, 0, 0, 5'b01000, 17, 0, 0, 1, 4'b0001, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 8'h00, 12'h003, 24'd17, 0, 5'h00, 0, 0, 0, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 1));
      // round-robin on 1011, rr starts at 1 -> grants 1,3,0,1
      tbl.push_back(mk(0, 1, 0, 0, 4'b1011, 8'h55, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b1011, 8'h55, 12'h000, 24'd0, 0, 5'h00, 1, 0, 0, 5'b00000, 17, 1, 0, 1, 4'b0010, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b1011, 8'h55, 12'h000, 24'd0, 0, 5'h00, 1, 0, 0, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b1011, 8'h55, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 17, 1, 0, 0, 4'b1000, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b1011, 8'h55, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b1011, 8'h55, 12'h000, 24'd0, 0, 5'h00, 1, 0, 0, 5'b00000, 17, 1, 0, 1, 4'b0001, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b1011, 8'h55, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b1011, 8'h55, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 17, 1, 0, 0, 4'b0010, 0, 1));
      // bypass burst from requester 2
      tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 8'h55, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 8'h55, 12'h000, 24'd0, 0, 5'h00, 1, 0, 0, 5'b00000, 17, 1, 0, 1, 4'b0100, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 8'h55, 12'h000, 24'd0, 0, 5'h00, 1, 0, 0, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 8'h55, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 17, 1, 0, 0, 4'b0100, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 8'h55, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 8'h55, 12'h000, 24'd0, 0, 5'h00, 1, 0, 0, 5'b00000, 17, 1, 0, 1, 4'b0100, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 8'h55, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 8'h55, 12'h000, 24'd0, 0, 5'h00, 1, 0, 0, 5'b00000, 17, 1, 0, 1, 4'b0100, 0, 1));
      // terminate from requester 1, bin=1 ends the slice
      tbl.push_back(mk(0, 1, 0, 0, 4'b0010, 8'h08, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0010, 8'h08, 12'h000, 24'd0, 0, 5'h00, 0, 1, 0, 5'b00000, 17, 0, 1, 1, 4'b0010, 1, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0010, 8'h08, 12'h000, 24'd0, 0, 5'h00, 0, 1, 0, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 4'b0010, 8'h08, 12'h000, 24'd0, 0, 5'h00, 0, 1, 0, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 0));

      rst = 1'b1; en = 1'b1; i_slice_start = 1'b0; i_init_done = 1'b0;
      i_req = '0; i_req_type = '0; i_req_bank = '0; i_req_idx = '0;
      i_valid = 1'b0; i_bin_ctx = '0; i_bin_byp = 1'b0; i_bin_term = 1'b0;
      repeat (2) @(posedge clk);

      foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

      // Stall: new slice, ctx bin on bank 1 idx 42, en=0 for 5 cycles in CTX2
      // while the request fields change underneath (they must be ignored).
      apply(mk(0, 1, 1, 0, 4'b0000, 8'h00, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 0), "restart");
      apply(mk(0, 1, 0, 0, 4'b0000, 8'h00, 12'h000, 24'd0, 0, 5'h00, 0, 0, 1, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 1), "reinit");
      apply(mk(0, 1, 0, 1, 4'b0000, 8'h00, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 1), "rewait");
      apply(mk(0, 1, 0, 0, 4'b0001, 8'h00, 12'h001, 24'd42, 0, 5'h00, 0, 0, 0, 5'b00000, 17, 0, 0, 0, 4'b0000, 0, 1), "stall_grant");
      apply(mk(0, 1, 0, 0, 4'b0001, 8'h00, 12'h001, 24'd42, 0, 5'h00, 0, 0, 0, 5'b00010, 42, 0, 0, 0, 4'b0000, 0, 1), "stall_ctx1");
      apply(mk(0, 1, 0, 0, 4'b0001, 8'h00, 12'h001, 24'd42, 0, 5'h00, 0, 0, 0, 5'b00010, 42, 0, 0, 0, 4'b0000, 0, 1), "stall_ctx2_novalid");
      for (int i = 0; i < 5; i++)
         apply(mk(0, 0, 0, 0, 4'b0001, 8'h00, 12'h004, 24'd5, 1, 5'h02, 1, 1, 0, 5'b00000, 42, 0, 0, 0, 4'b0000, 0, 1),
               $sformatf("stall_en0_%0d", i));
      apply(mk(0, 1, 0, 0, 4'b0001, 8'h00, 12'h004, 24'd5, 1, 5'h02, 0, 0, 0, 5'b00010, 42, 0, 0, 1, 4'b0001, 0, 1), "stall_release");

      // Bank 7 on requester 1 maps to bank 0
      apply(mk(0, 1, 0, 0, 4'b0010, 8'h00, 12'h038, 24'd576, 0, 5'h00, 0, 0, 0, 5'b00000, 42, 0, 0, 0, 4'b0000, 0, 1), "bank7_grant");
      apply(mk(0, 1, 0, 0, 4'b0010, 8'h00, 12'h038, 24'd576, 0, 5'h00, 0, 0, 0, 5'b00001, 9, 0, 0, 0, 4'b0000, 0, 1), "bank7_ctx1");
      apply(mk(0, 1, 0, 0, 4'b0010, 8'h00, 12'h038, 24'd576, 1, 5'h01, 0, 0, 0, 5'b00001, 9, 0, 0, 1, 4'b0010, 0, 1), "bank7_ctx2");

      // Abort in CTX1 by i_slice_start: no bin, o_init next cycle
      apply(mk(0, 1, 0, 0, 4'b0010, 8'h00, 12'h038, 24'd576, 1, 5'h1f, 0, 0, 0, 5'b00000, 9, 0, 0, 0, 4'b0000, 0, 1), "abort_grant");
      apply(mk(0, 1, 1, 0, 4'b0010, 8'h00, 12'h038, 24'd576, 1, 5'h1f, 0, 0, 0, 5'b00000, 9, 0, 0, 0, 4'b0000, 0, 1), "abort_ctx1");
      apply(mk(0, 1, 0, 0, 4'b0000, 8'h00, 12'h000, 24'd0, 0, 5'h00, 0, 0, 1, 5'b00000, 9, 0, 0, 0, 4'b0000, 0, 1), "abort_init");
      apply(mk(0, 1, 0, 1, 4'b0000, 8'h00, 12'h000, 24'd0, 0, 5'h00, 0, 0, 0, 5'b00000, 9, 0, 0, 0, 4'b0000, 0, 1), "abort_wait");

      // Reserved type: rr kept at 2 -> requester 2, bin 0, no strobe
      apply(mk(0, 1, 0, 0, 4'b1111, 8'hFF, 12'h000, 24'd0, 0, 5'h00, 1, 1, 0, 5'b00000, 9, 0, 0, 0, 4'b0000, 0, 1), "rsv_grant");
      apply(mk(0, 1, 0, 0, 4'b1111, 8'hFF, 12'h000, 24'd0, 0, 5'h00, 1, 1, 0, 5'b00000, 9, 0, 0, 0, 4'b0100, 0, 1), "rsv_done");

      // Reset mid-bin: requester 3 ctx idx 33, rst in CTX2, nothing delivered
      apply(mk(0, 1, 0, 0, 4'b1111, 8'h00, 12'h000, {6'd33, 18'd0}, 0, 5'h00, 0, 0, 0, 5'b00000, 9, 0, 0, 0, 4'b0000, 0, 1), "rst_grant");
      apply(mk(0, 1, 0, 0, 4'b1111, 8'h00, 12'h000, {6'd33, 18'd0}, 0, 5'h00, 0, 0, 0, 5'b00001, 33, 0, 0, 0, 4'b0000, 0, 1), "rst_ctx1");
      apply(mk(1, 1, 0, 0, 4'b1111, 8'h00, 12'h000, {6'd33, 18'd0}, 0, 5'h00, 0, 0, 0, 5'b00001, 33, 0, 0, 0, 4'b0000, 0, 1), "rst_ctx2");
      apply(mk(0, 1, 0, 0, 4'b0000, 8'h00, 12'h000, 24'd0, 1, 5'h1f, 1, 1, 0, 5'b00000, 0, 0, 0, 0, 4'b0000, 0, 0), "rst_idle");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/cabac_bin_sched.md
Name: cabac_bin_sched

Overview:
Sequences the shared CABAC arithmetic decoder between several syntax-element parsers (CU/SD/XY-prefix/SIG/GT1 parsers). It runs the per-slice engine init handshake and arbitrates bin requests round-robin. It drives exactly one decode strobe per bin and routes the decoded bin back to the winning requester. It absorbs engine timing: context bins take 2 cycles, bypass and terminate bins take 1 cycle.

Parameters:
NREQ, 4, number of requesters (2..8)
IDXW, 6, context-index width on the request bus

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  global enable; 0 freezes all state and forces all strobes low
i_slice_start  in  1  pulse: new slice data begins
i_init_done  in  1  context tables initialised (from engine)
o_init  out  1  one-cycle engine range/offset init pulse
i_req  in  NREQ  per-requester bin request, held until o_bin_vld for it
i_req_type  in  2*NREQ  per requester: 0 ctx, 1 bypass, 2 terminate, 3 reserved
i_req_bank  in  3*NREQ  ctx bank: 0 cu, 1 sd, 2 xy_pref, 3 sig, 4 gt1
i_req_idx  in  IDXW*NREQ  context index
o_dec_en  out  5  one-hot ctx decode strobe per bank (bit = bank)
o_cm_idx  out  IDXW  context index for active bank
o_byp_en  out  1  bypass strobe
o_term_en  out  1  terminate strobe
i_valid  in  1  engine ctx-bin valid
i_bin_ctx  in  5  per-bank ctx bin outputs
i_bin_byp  in  1  bypass bin
i_bin_term  in  1  terminate bin
o_bin  out  1  decoded bin
o_bin_vld  out  NREQ  one-hot: bin for requester k valid this cycle
o_slice_end  out  1  pulse: terminate bin = 1 decoded
o_busy  out  1  not in IDLE

Behaviour:
- Reset: state IDLE, rr pointer 0, all outputs 0.
- en=0: no state or pointer change; o_dec_en, o_byp_en, o_term_en, o_init and o_bin_vld are 0. o_cm_idx holds its value.
- IDLE -> INIT on i_slice_start. INIT asserts o_init for 1 cycle -> WAIT_INIT. WAIT_INIT stays until i_init_done=1 -> ARB.
- ARB: round-robin over i_req starting at the rr pointer; the winner index is latched as g. If there is no request, stay in ARB.
  - ctx -> CTX1.
  - bypass -> BYP.
  - terminate -> TERM.
  - rr pointer = g+1 mod NREQ, updated on grant.
- Request fields are latched at grant. Later changes to i_req_* are ignored until that bin completes.
- CTX1: o_dec_en[bank]=1, o_cm_idx=idx -> CTX2.
- CTX2: o_dec_en[bank] held at 1.
  - When i_valid=1: o_bin=i_bin_ctx[bank], o_bin_vld[g]=1 -> ARB.
  - If i_valid=0 in CTX2, stay in CTX2 with the strobe held. Protocol error; the engine normally never does this.
- BYP: o_byp_en=1, o_bin=i_bin_byp, o_bin_vld[g]=1 in the same cycle -> ARB.
- TERM: o_term_en=1, o_bin=i_bin_term, o_bin_vld[g]=1.
  - bin=1: o_slice_end=1 -> IDLE.
  - bin=0: -> ARB.
- Throughput: ctx bin 2 cycles + 1 ARB cycle; bypass/term 1 + 1 cycle.
- Bank value >4 is treated as bank 0.
- Type 3 is granted and completed in 1 cycle with o_bin=0, o_bin_vld set, no strobe.
- i_slice_start outside IDLE: aborts the current bin (no o_bin_vld) -> INIT. The rr pointer is kept.
- Strobes: at most one strobe among o_dec_en/o_byp_en/o_term_en is ever high in a cycle.
- rst mid-bin: immediate return to IDLE, no bin delivered.

Optional Feature:
CABAC_SCHED_STATS_EN:
- Defined: adds 32-bit output ports o_cnt_ctx, o_cnt_byp and o_cnt_term.
- Each counter increments on the corresponding o_bin_vld cycle and wraps at 2^32.
- All three counters clear on rst and on entry to INIT.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Init: rst, i_slice_start, i_init_done rises 3 cycles later -> o_init 1 pulse; ARB reached the cycle after i_init_done=1.
- Ctx bin: req0 ctx bank 3 idx 17 -> o_dec_en=5'b01000 and o_cm_idx=17 for 2 cycles; the 2nd cycle has i_valid=1, i_bin_ctx[3]=1 -> o_bin=1, o_bin_vld=4'b0001.
- Round-robin: i_req=4'b1011 held -> grants in order 0,1,3,0,...; each grant cycle shows exactly one strobe.
- Bypass burst: req2 issues 4 bypass bins -> o_byp_en high every 2nd cycle, o_bin = i_bin_byp in that cycle, o_bin_vld=4'b0100.
- Terminate: req1 term, i_bin_term=1 -> o_slice_end pulse, o_busy=0 next cycle; further i_req are ignored until i_slice_start.
- Stall/abort: en=0 during CTX2 for 5 cycles -> strobes low and state held, bin delivered after en returns. i_slice_start mid-CTX1 -> no o_bin_vld, o_init asserted next cycle.
